// File: rtl/fetch_sequencer.sv
// fetch_sequencer: stall-aware PC sequencer issuing one imem request per instruction and handing words to decode.
// Optional FETCH_TRACE_EN prints transfers and HALT/ERR entry in simulation; behaviour is unchanged.
module fetch_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  output logic              halted,
  output logic              fetch_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT, ERR} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] wait_cnt;
  logic halt_pend;
  logic stop;
  assign imem_addr = pc;
  // a halt seen while the fetch is outstanding is remembered until its transfer
  assign stop = halt | halt_pend;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      wait_cnt <= '0;
      halt_pend <= 1'b0;
      imem_req <= 1'b0;
      instr_valid <= 1'b0;
      halted <= 1'b0;
      fetch_err <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= halt ? HALT : REQ;
          imem_req <= !halt;
          halted <= halt;
        end
        REQ: begin
          imem_req <= 1'b0;
          wait_cnt <= '0;
          halt_pend <= 1'b0;
          state <= halt ? HALT : WAIT;
          halted <= halt;
        end
        WAIT: begin
          if (halt) halt_pend <= 1'b1;
          if (imem_ack) begin
            instr <= imem_rdata;
            instr_pc <= pc;
            instr_valid <= 1'b1;
            state <= HOLD;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            state <= ERR;
            fetch_err <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc <= br_taken ? br_target : pc + 1'b1;
            state <= stop ? HALT : REQ;
            imem_req <= !stop;
            halted <= stop;
          end
        end
        default: ;
      endcase
    end
  end
`ifdef FETCH_TRACE_EN
  always @(posedge clk)
    if (!reset && state == HOLD && instr_ready)
      $strobe("%0t fetch pc=%h instr=%h br=%b next_pc=%h", $time, instr_pc, instr, br_taken, pc);
  always @(state) begin
    if (state == HALT) $display("%0t fetch_sequencer halted, pc=%h", $time, pc);
    if (state == ERR) $display("%0t fetch_sequencer fetch timeout, pc=%h", $time, pc);
  end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vectors with hand-computed expectations for fetch_sequencer.
module tb_fetch_sequencer;
  logic clk = 0;
  logic reset = 1;
  logic imem_ack = 0;
  logic [31:0] imem_rdata = 0;
  logic instr_ready = 0;
  logic br_taken = 0;
  logic [31:0] br_target = 0;
  logic halt = 0;
  logic imem_req, instr_valid, halted, fetch_err;
  logic [31:0] imem_addr, instr, instr_pc;
  logic req2, valid2, halted2, err2;
  logic [31:0] addr2, instr2, pc2;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .halted(halted), .fetch_err(fetch_err)
  );
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(valid2),
    .instr(instr2), .instr_pc(pc2), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .halted(halted2), .fetch_err(err2)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // caller is one cycle into REQ; d = WAIT cycle carrying the ack, r = HOLD cycles without ready
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] data, input int d, input int r,
                           input logic br, input logic [31:0] tgt, input logic bw, input logic hw);
    chk("req", imem_req, 1);
    chk("addr", imem_addr, a);
    tick();
    if (bw) begin br_taken = 1; br_target = 32'h99; end
    if (hw) halt = 1;
    for (int i = 1; i < d; i++) begin
      tick();
      br_taken = 0;
      halt = 0;
      chk("wait_req", imem_req, 0);
      chk("wait_valid", instr_valid, 0);
    end
    imem_ack = 1;
    imem_rdata = data;
    tick();
    imem_ack = 0;
    br_taken = 0;
    halt = 0;
    chk("valid", instr_valid, 1);
    chk("instr", instr, data);
    chk("instr_pc", instr_pc, a);
    for (int i = 0; i < r; i++) begin
      tick();
      chk("hold_instr", instr, data);
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", imem_addr, a);
      chk("hold_req", imem_req, 0);
    end
    instr_ready = 1;
    br_taken = br;
    br_target = tgt;
    tick();
    instr_ready = 0;
    br_taken = 0;
    chk("xfer_valid", instr_valid, 0);
    chk("xfer_req", imem_req, !hw);
    chk("xfer_halted", halted, hw);
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    tick();
  endtask
  initial begin
    do_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_addr_wrap", addr2, 32'hFFFF_FFFF);
    reset = 0;
    tick();
    chk("idle_to_req", imem_req, 1);
    fetch_one(0, 32'hA000_0000, 1, 0, 0, 0, 0, 0);
    chk("wrap_addr", addr2, 0);
    fetch_one(1, 32'hA000_0001, 1, 0, 0, 0, 0, 0);
    fetch_one(2, 32'hA000_0002, 1, 0, 1, 32'h40, 0, 0);
    fetch_one(32'h40, 32'hB000_0040, 5, 4, 0, 0, 1, 0);
    fetch_one(32'h41, 32'hB000_0041, 1, 0, 0, 0, 0, 0);
    // timeout: 15 WAIT cycles without ack
    do_reset();
    reset = 0;
    tick();
    chk("to_req", imem_req, 1);
    tick();
    repeat (14) tick();
    chk("to_pre_err", fetch_err, 0);
    tick();
    chk("to_err", fetch_err, 1);
    chk("to_req_off", imem_req, 0);
    chk("to_valid", instr_valid, 0);
    repeat (3) tick();
    chk("to_err_sticky", fetch_err, 1);
    chk("to_no_req", imem_req, 0);
    do_reset();
    chk("to_rst_err", fetch_err, 0);
    reset = 0;
    tick();
    fetch_one(0, 32'hC000_0000, 15, 0, 0, 0, 0, 0);
    chk("lim_ack_err", fetch_err, 0);
    // halt during WAIT
    fetch_one(1, 32'hD000_0001, 3, 1, 0, 0, 0, 1);
    repeat (5) tick();
    chk("halt_req", imem_req, 0);
    chk("halt_state", halted, 1);
    chk("halt_pc", imem_addr, 2);
    // reset mid-WAIT with a late ack
    do_reset();
    reset = 0;
    tick();
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    imem_ack = 1;
    imem_rdata = 32'hDEAD_BEEF;
    chk("late_idle_halted", halted, 0);
    tick();
    chk("late_req", imem_req, 1);
    chk("late_addr", imem_addr, 0);
    tick();
    imem_ack = 0;
    chk("late_valid", instr_valid, 0);
    imem_ack = 1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 0;
    chk("late_instr", instr, 32'h1234_5678);
    chk("late_instr_pc", instr_pc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
